// File: rtl/pcap_replay_tx_arbiter_pkg.sv
// pcap_replay_tx_arbiter_pkg
//   Shared definitions for the replay TX arbiter:
//   - state_t : arbiter FSM states (IDLE / ARB / XFER)
//   - log2c   : ceil(log2(n)), minimum 1, used to size queue indices
package pcap_replay_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    function automatic int unsigned log2c(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if (n > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pcap_replay_rr_select.sv
// pcap_replay_rr_select
//   Combinational round-robin first-set search over an N-bit mask.
//   Search order: rr_ptr, rr_ptr+1, ... wrapping modulo N.
// Ports
//   i_eligible  in  N      candidate mask
//   i_rr_ptr    in  PTR_W  index where the search starts
//   o_index     out PTR_W  first set index found (0 when none)
//   o_found     out 1      any bit of i_eligible set
module pcap_replay_rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [PTR_W-1:0] o_index,
    output logic             o_found
);

    // One spare bit so rr_ptr + k cannot overflow before the wrap.
    logic [PTR_W:0] w_idx;

    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N)) w_idx = w_idx - (PTR_W+1)'(N);
            if (!o_found && i_eligible[w_idx[PTR_W-1:0]]) begin
                o_index = w_idx[PTR_W-1:0];
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcap_replay_tx_arbiter.sv
// pcap_replay_tx_arbiter
//   Packet-granular round-robin arbiter merging NUM_QUEUES AXI-Stream replay
//   streams onto one output port. A run is started/stopped by software; each
//   queue has a packet budget (0 = unlimited). Packets are never split.
// Ports
//   axi_aclk, rst, sw_rst        clock, synchronous active-high resets
//   s_axis_t{data,strb,user,valid,last} / s_axis_tready   per-queue inputs (flat buses)
//   m_axis_t{data,strb,user,valid,last} / m_axis_tready   merged output
//   start, stop                  run control pulses
//   queue_en, pkt_limit          run configuration, latched on start
//   pkt_count                    packets sent per queue in current/last run
//   busy, done                   run active; one-cycle pulse on return to IDLE
module pcap_replay_tx_arbiter
    import pcap_replay_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_QUEUES           = 4,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                                        axi_aclk,
    input  logic                                        rst,
    input  logic                                        sw_rst,
    input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                       s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                       s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                       s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    input  logic                                        m_axis_tready,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic [NUM_QUEUES-1:0]                       queue_en,
    input  logic [NUM_QUEUES*CNT_WIDTH-1:0]             pkt_limit,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]             pkt_count,
    output logic                                        busy,
    output logic                                        done
);

    localparam int unsigned N     = NUM_QUEUES;
    localparam int unsigned DW    = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned SW    = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW    = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned CW    = CNT_WIDTH;
    localparam int unsigned PTR_W = log2c(NUM_QUEUES);

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_en;
    logic [N*CW-1:0]  r_lim;
    logic [N*CW-1:0]  r_cnt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_grant;
    logic             r_stop_pend;
    logic             r_done;

    logic             w_rst;
    logic [N-1:0]     w_under;
    logic [N-1:0]     w_eligible;
    logic [N-1:0]     w_exhausted;
    logic [PTR_W-1:0] w_sel_idx;
    logic             w_sel_found;
    logic             w_accept;
    logic             w_take_grant;
    logic             w_pkt_end;
    logic             w_finish;

    assign w_rst = rst | sw_rst;

    // Budget is evaluated only here, at grant time; a granted packet always completes.
    always_comb begin
        w_under     = '0;
        w_eligible  = '0;
        w_exhausted = '0;
        for (int unsigned q = 0; q < N; q++) begin
            w_under[q]     = (r_lim[q*CW +: CW] == '0) || (r_cnt[q*CW +: CW] < r_lim[q*CW +: CW]);
            w_eligible[q]  = r_en[q] & w_under[q] & s_axis_tvalid[q];
            w_exhausted[q] = ~r_en[q] | ~w_under[q];
        end
    end

    pcap_replay_rr_select #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_index    (w_sel_idx),
        .o_found    (w_sel_found)
    );

    always_ff @(posedge axi_aclk) begin
        if (w_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_take_grant  = 1'b0;
        w_pkt_end     = 1'b0;
        w_finish      = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ARB;
                end
            end
            ST_ARB: begin
                if (r_stop_pend || (&w_exhausted)) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_sel_found) begin
                    w_take_grant = 1'b1;
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                m_axis_tdata           = s_axis_tdata[r_grant*DW +: DW];
                m_axis_tstrb           = s_axis_tstrb[r_grant*SW +: SW];
                m_axis_tuser           = s_axis_tuser[r_grant*UW +: UW];
                m_axis_tvalid          = s_axis_tvalid[r_grant];
                m_axis_tlast           = s_axis_tlast[r_grant];
                s_axis_tready[r_grant] = m_axis_tready;
                if (s_axis_tvalid[r_grant] && m_axis_tready && s_axis_tlast[r_grant]) begin
                    w_pkt_end    = 1'b1;
                    w_next_state = ST_ARB;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (w_rst) begin
            r_en        <= '0;
            r_lim       <= '0;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_en     <= queue_en;
                r_lim    <= pkt_limit;
                r_cnt    <= '0;
                r_rr_ptr <= '0;
            end
            if (w_take_grant) r_grant <= w_sel_idx;
            if (w_pkt_end) begin
                for (int unsigned q = 0; q < N; q++) begin
                    if (r_grant == PTR_W'(q) && r_cnt[q*CW +: CW] != '1)
                        r_cnt[q*CW +: CW] <= r_cnt[q*CW +: CW] + CW'(1);
                end
                r_rr_ptr <= (r_grant == PTR_W'(N-1)) ? '0 : r_grant + PTR_W'(1);
            end
            // Stop in IDLE is ignored; a stop landing on the finishing cycle is dropped.
            if (w_finish)                         r_stop_pend <= 1'b0;
            else if (stop && r_state != ST_IDLE)  r_stop_pend <= 1'b1;
        end
    end

    assign pkt_count = r_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule
